wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/wb_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back bus between the requesters/decoder and the write-back arbiter.
// Carries request handshakes, scoreboard control and register-file write port.
interface wb_arbiter_if #(
  parameter int unsigned REGISTER_WIDTH   = 64,
  parameter int unsigned REGISTERNO_WIDTH = 5
);
  logic [2:0]                      req_valid;
  logic [3*REGISTERNO_WIDTH-1:0]   req_regno;
  logic [3*REGISTER_WIDTH-1:0]     req_value;
  logic [2:0]                      req_ready;
  logic                            issue_set;
  logic [REGISTERNO_WIDTH-1:0]     issue_regno;
  logic                            flush;
  logic                            rf_wr_enable;
  logic [REGISTERNO_WIDTH-1:0]     rf_rd_regno;
  logic [REGISTER_WIDTH-1:0]       rf_rd_value;
  logic [2**REGISTERNO_WIDTH-1:0]  busy;
  logic [31:0]                     conflict_count;

  modport master (
    output req_valid, req_regno, req_value, issue_set, issue_regno, flush,
    input  req_ready, rf_wr_enable, rf_rd_regno, rf_rd_value, busy, conflict_count
  );

  modport slave (
    input  req_valid, req_regno, req_value, issue_set, issue_regno, flush,
    output req_ready, rf_wr_enable, rf_rd_regno, rf_rd_value, busy, conflict_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter (ALU/MEM/MUL) with pending-register scoreboard.
// Define WB_CONFLICT_COUNT_EN to build the contention counter.
module wb_arbiter #(
  parameter int unsigned REGISTER_WIDTH   = 64,
  parameter int unsigned REGISTERNO_WIDTH = 5
) (
  input logic        clk,
  input logic        reset,
  wb_arbiter_if.slave bus
);
  localparam int unsigned NumRegs = 2 ** REGISTERNO_WIDTH;

  logic [1:0]                  ptr_q, ptr_d;
  logic [2:0]                  grant;
  logic                        transfer;
  logic [REGISTERNO_WIDTH-1:0] sel_regno;
  logic [REGISTER_WIDTH-1:0]   sel_value;
  logic [NumRegs-1:0]          busy_q, busy_d;
  logic                        wr_en_q;
  logic [REGISTERNO_WIDTH-1:0] rd_regno_q;
  logic [REGISTER_WIDTH-1:0]   rd_value_q;

  // First valid requester in the order a, b, c.
  function automatic logic [2:0] pick(input logic [2:0] v, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] c);
    logic [2:0] g;
    g = 3'b000;
    if (v[a])      g = 3'b001 << a;
    else if (v[b]) g = 3'b001 << b;
    else if (v[c]) g = 3'b001 << c;
    return g;
  endfunction

  always_comb begin
    grant = 3'b000;
    if (!reset) begin
      unique case (ptr_q)
        2'd0:    grant = pick(bus.req_valid, 2'd0, 2'd1, 2'd2);
        2'd1:    grant = pick(bus.req_valid, 2'd1, 2'd2, 2'd0);
        default: grant = pick(bus.req_valid, 2'd2, 2'd0, 2'd1);
      endcase
    end
  end

  assign transfer      = |grant;
  assign bus.req_ready = grant;

  always_comb begin
    sel_regno = bus.req_regno[0 +: REGISTERNO_WIDTH];
    sel_value = bus.req_value[0 +: REGISTER_WIDTH];
    ptr_d     = ptr_q;
    unique case (grant)
      3'b001: ptr_d = 2'd1;
      3'b010: begin
        sel_regno = bus.req_regno[REGISTERNO_WIDTH +: REGISTERNO_WIDTH];
        sel_value = bus.req_value[REGISTER_WIDTH +: REGISTER_WIDTH];
        ptr_d     = 2'd2;
      end
      3'b100: begin
        sel_regno = bus.req_regno[2*REGISTERNO_WIDTH +: REGISTERNO_WIDTH];
        sel_value = bus.req_value[2*REGISTER_WIDTH +: REGISTER_WIDTH];
        ptr_d     = 2'd0;
      end
      default: ptr_d = ptr_q;
    endcase
  end

  // Issue wins over both write-back clear and flush; x0 is never pending.
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else if (wr_en_q) begin
      busy_d[rd_regno_q] = 1'b0;
    end
    if (bus.issue_set && (bus.issue_regno != '0)) begin
      busy_d[bus.issue_regno] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= 2'd0;
      busy_q     <= '0;
      wr_en_q    <= 1'b0;
      rd_regno_q <= '0;
      rd_value_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      wr_en_q <= transfer && (sel_regno != '0);
      if (transfer) begin
        rd_regno_q <= sel_regno;
        rd_value_q <= sel_value;
      end
    end
  end

  assign bus.rf_wr_enable = wr_en_q;
  assign bus.rf_rd_regno  = rd_regno_q;
  assign bus.rf_rd_value  = rd_value_q;
  assign bus.busy         = busy_q;

`ifdef WB_CONFLICT_COUNT_EN
  logic [31:0] conflict_q;
  logic        conflict;

  assign conflict = (bus.req_valid[0] & bus.req_valid[1]) |
                    (bus.req_valid[0] & bus.req_valid[2]) |
                    (bus.req_valid[1] & bus.req_valid[2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= '0;
    end else if (conflict) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign bus.conflict_count = conflict_q;
`else
  assign bus.conflict_count = '0;
`endif
endmodule
